// File: rtl/lm_arbiter.sv
// Round-robin arbiter sharing the LED manager FIFO write port, with a hold gap after every write.
// Optional macro LM_ERR_PRIORITY_EN: requester 0 gets absolute priority and may cut a hold short.
module lm_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     fifo_full,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         wr_data,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [WIDTH-1:0]  wr_data_reg, wr_data_next;
  logic [ID_W-1:0]   grant_id_reg, grant_id_next;

  logic [WIDTH-1:0]  slot_data [NUM_REQ];
  logic [ID_W-1:0]   cand_idx  [NUM_REQ];
  logic [ID_W-1:0]   rr_winner;
  logic              rr_found;
  logic              prio_req;

  // cand_idx[k] is the k-th requester visited when searching upward from rr_ptr
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      logic [ID_W:0] sum;
      assign slot_data[gi] = req_data[gi*WIDTH +: WIDTH];
      assign sum           = {1'b0, rr_ptr_reg} + (ID_W + 1)'(gi);
      assign cand_idx[gi]  = (sum >= NUM_REQ_W) ? ID_W'(sum - NUM_REQ_W) : sum[ID_W-1:0];
    end
  endgenerate

  always_comb begin
    rr_winner = '0;
    rr_found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        rr_winner = cand_idx[k];
        rr_found  = 1'b1;
      end
    end
  end

`ifdef LM_ERR_PRIORITY_EN
  assign prio_req = req[0] && !fifo_full;
`else
  assign prio_req = 1'b0;
`endif

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] w);
    return (w == LAST_ID) ? '0 : w + ID_W'(1);
  endfunction

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    cnt_next      = cnt_reg;
    wr_data_next  = wr_data_reg;
    grant_id_next = grant_id_reg;
    case (state_reg)
      IDLE: begin
        if (prio_req) begin
          state_next    = WRITE;
          grant_id_next = '0;
          wr_data_next  = slot_data[0];
        end else if (!fifo_full && rr_found) begin
          state_next    = WRITE;
          grant_id_next = rr_winner;
          wr_data_next  = slot_data[rr_winner];
          rr_ptr_next   = ptr_after(rr_winner);
        end
      end
      WRITE: begin
        if (HOLD_CYCLES > 0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        // the error channel may cut the hold short; rr_ptr is left untouched
        if (prio_req) begin
          state_next    = WRITE;
          grant_id_next = '0;
          wr_data_next  = slot_data[0];
        end else if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      cnt_reg      <= '0;
      wr_data_reg  <= '0;
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      cnt_reg      <= cnt_next;
      wr_data_reg  <= wr_data_next;
      grant_id_reg <= grant_id_next;
    end
  end

  assign wr_en    = (state_reg == WRITE);
  assign busy     = (state_reg != IDLE);
  assign wr_data  = wr_data_reg;
  assign grant_id = grant_id_reg;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack[gi] = wr_en && (grant_id_reg == ID_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_lm_arbiter.sv
// Randomized scoreboard bench for lm_arbiter against a cycle-numbered reference of the arbitration rules.
// Honours LM_ERR_PRIORITY_EN in the reference model when the macro is defined.
module tb_lm_arbiter;
  localparam int NUM  = 4;
  localparam int HOLD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM-1:0]    req;
  logic [NUM*8-1:0]  req_data;
  logic [NUM-1:0]    ack;
  logic              fifo_full;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic [1:0]        grant_id;
  logic              busy;

  lm_arbiter #(.NUM_REQ(NUM), .ID_W(2), .WIDTH(8), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // requester agent state
  logic           rst_v;
  logic [NUM-1:0] req_v;
  logic [7:0]     dat_v [NUM];
  logic           full_v;
  int             mode;  // 0 keep requesting, 1 drop after ack, 2 random
  logic [NUM-1:0] locked;
  int             rel_edge [NUM];

  assign rst_n     = rst_v;
  assign req       = req_v;
  assign fifo_full = full_v;
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM; i++) req_data[i*8 +: 8] = dat_v[i];
  end

  // reference model: cycle n is the cycle that follows clock edge n
  int         cyc = 0;
  int         rr, last_w, next_ok;
  bit         have_w;
  logic [1:0] exp_gid;
  logic [7:0] exp_data;

  typedef struct { int cyc; logic [7:0] data; int id; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    int n;
    int win;
    bit can_n, can_p;
    n = cyc;
    if (!rst_v) begin
      rr = 0; have_w = 0; next_ok = n + 1; exp_gid = '0; exp_data = '0; locked = '0;
    end else begin
      can_n = (n >= next_ok);
      can_p = 0;
`ifdef LM_ERR_PRIORITY_EN
      can_p = have_w && (n >= last_w + 2) && (n <= last_w + HOLD + 1);
`endif
      win = -1;
      if (!full_v && req_v != '0) begin
`ifdef LM_ERR_PRIORITY_EN
        if (req_v[0] && (can_n || can_p)) win = 0;
`endif
        if (win < 0 && can_n)
          for (int k = 0; k < NUM; k++)
            if (win < 0 && req_v[(rr + k) % NUM]) win = (rr + k) % NUM;
      end
      if (win >= 0) begin
        q.push_back('{cyc: n, data: dat_v[win], id: win});
`ifdef LM_ERR_PRIORITY_EN
        if (win != 0) rr = (win + 1) % NUM;
`else
        rr = (win + 1) % NUM;
`endif
        have_w = 1; last_w = n; next_ok = n + HOLD + 2;
        exp_gid = 2'(win); exp_data = dat_v[win];
        locked[win] = 1'b1; rel_edge[win] = n + 1;
      end
      // requester leaves the ack cycle: drop or present fresh data
      for (int i = 0; i < NUM; i++) begin
        if (locked[i] && rel_edge[i] == n) begin
          locked[i] = 1'b0;
          if (mode == 1) req_v[i] = 1'b0;
          else if (mode == 2) begin
            if ($urandom_range(0, 1) == 0) req_v[i] = 1'b0;
            else dat_v[i] = 8'($urandom);
          end
        end
      end
    end
    if (mode == 2) begin
      full_v = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM; i++) begin
        if (!locked[i]) begin
          if (!req_v[i]) begin
            dat_v[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req_v[i] = 1'b1;
          end else if ($urandom_range(0, 15) == 0) begin
            req_v[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic run(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      step();
    end
  endtask

  task automatic quiesce();
    mode   = 1;
    full_v = 1'b0;
    req_v  = req_v & locked;
    run(HOLD + 6);
  endtask

  // monitor: pops the scoreboard whenever the DUT writes, checks held outputs every cycle
  initial begin
    exp_t e;
    bit   busy_exp;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          chk("unexpected_wr_en", 32'(wr_en), 32'd0);
        end else begin
          e = q.pop_front();
          chk("wr_data", 32'(wr_data), 32'(e.data));
          chk("ack", 32'(ack), 32'd1 << e.id);
          chk("write_grant", 32'(grant_id), 32'(e.id));
        end
      end else begin
        chk("ack_idle", 32'(ack), 32'd0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chk("missing_wr_en", 32'(wr_en), 32'd1);
          void'(q.pop_front());
        end
      end
      busy_exp = have_w && ((cyc - last_w) <= HOLD);
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("grant_id", 32'(grant_id), 32'(exp_gid));
      chk("wr_data_held", 32'(wr_data), 32'(exp_data));
    end
  end

  initial begin
    rst_v = 1'b0; req_v = '1; full_v = 1'b0; mode = 0; locked = '0;
    for (int i = 0; i < NUM; i++) begin dat_v[i] = 8'($urandom); rel_edge[i] = 0; end
    run(3);
    // single requester, then all four with fixed data for a full rotation
    rst_v = 1'b1; mode = 1; req_v = 4'b0100; dat_v[2] = 8'hA5;
    run(10);
    mode = 0; req_v = 4'hF;
    for (int i = 0; i < NUM; i++) dat_v[i] = 8'h10 + 8'(i);
    run(32);
    quiesce();
    // write held off by a full FIFO
    full_v = 1'b1; req_v = 4'b0010; dat_v[1] = 8'h3C;
    run(10);
    full_v = 1'b0;
    run(10);
    quiesce();
    mode = 2;
    run(3000);
    quiesce();
    run(4);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
